// File: rtl/merge_pkg.sv
// merge_pkg: shared constants and FSM state type for the merge network wrappers
package merge_pkg;
    localparam int WIDTH_DEF = 3;
    localparam int N_DEF = 8;
    localparam int ELEMS_DEF = 2 * N_DEF;
    localparam int CNT_W_DEF = $clog2(ELEMS_DEF);
    typedef enum logic {IDLE, SEND} merge_state_t;
endpackage

// File: rtl/merge_order_checker.sv
// merge_order_checker: combinational check that a packed 2*N-element vector is nondecreasing
module merge_order_checker #(
    parameter int WIDTH = 3,
    parameter int N = 8
) (
    input  logic [2*N*WIDTH-1:0] vec,
    output logic                 sorted
);
    always_comb begin
        sorted = 1'b1;
        for (int k = 0; k < 2 * N - 1; k++)
            if (vec[k*WIDTH +: WIDTH] > vec[(k+1)*WIDTH +: WIDTH]) sorted = 1'b0;
    end
endmodule

// File: rtl/merge_stream_serializer.sv
// merge_stream_serializer: streams a captured sorted 2N-element vector one element per beat; MERGE_SER_SORT_CHECK_EN adds a sticky order check
module merge_stream_serializer
    import merge_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int N = N_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [2*N*WIDTH-1:0]           in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_data,
    output logic [$clog2(2*N)-1:0]         out_index,
    output logic                           out_last,
    output logic                           sort_err
);
    localparam int ELEMS = 2 * N;
    localparam int CNT_W = $clog2(ELEMS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ELEMS - 1);

    merge_state_t state, state_nxt;
    logic [WIDTH-1:0] mem [ELEMS];
    logic [CNT_W-1:0] idx;
    logic cap;

    assign out_valid = state == SEND;
    assign out_last = out_valid && idx == LAST;
    assign out_index = idx;
    assign out_data = out_valid ? mem[idx] : '0;
    // out_ready -> in_ready is combinational so a new vector can land on the last beat
    assign in_ready = state == IDLE || (out_last && out_ready);
    assign cap = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        if (cap) state_nxt = SEND;
        else if (out_last && out_ready) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            for (int k = 0; k < ELEMS; k++) mem[k] <= '0;
        end else begin
            state <= state_nxt;
            if (cap) begin
                idx <= '0;
                for (int k = 0; k < ELEMS; k++) mem[k] <= in_data[k*WIDTH +: WIDTH];
            end else if (out_valid && out_ready && !out_last) begin
                idx <= idx + 1'b1;
            end
        end
    end

`ifdef MERGE_SER_SORT_CHECK_EN
    logic sorted;

    merge_order_checker #(.WIDTH(WIDTH), .N(N)) u_chk (
        .vec(in_data),
        .sorted(sorted)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sort_err <= 1'b0;
        else if (cap && !sorted) sort_err <= 1'b1;
    end
`else
    assign sort_err = 1'b0;
`endif
endmodule

// File: doc/merge_stream_serializer.md
Name: merge_stream_serializer

Overview:
- Downstream stage of the 8+8 to 16 odd-even merge network.
- Registers one sorted 2*N-element vector per handshake and streams it out one element per beat, lowest element first, under valid/ready flow control.
- Lets a narrow consumer, such as the V2V message scheduler or a UART/FIFO bridge, read the merged priority list without holding the wide bus.

Parameters:
- WIDTH, 3, bit width of one element (key).
- N, 8, elements per merge input; the vector holds ELEMS = 2*N elements.
- CNT_W, $clog2(2*N), element index width (derived, not overridden).

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  merged vector on in_data is valid
- in_ready  output  1  block can capture a vector this cycle
- in_data  input  2*N*WIDTH  sorted vector; element k at [(k+1)*WIDTH-1:k*WIDTH], k=0 smallest
- out_valid  output  1  out_data holds a valid element
- out_ready  input  1  consumer accepts the element this cycle
- out_data  output  WIDTH  current element
- out_index  output  CNT_W  position (0..2N-1) of current element
- out_last  output  1  current element is index 2N-1
- sort_err  output  1  sticky ordering-violation flag (see Optional Feature)

Behaviour:
- Reset (async, rst=1): state=IDLE, buffer=0, idx=0, out_valid=0, out_last=0, out_index=0, out_data=0, sort_err=0. Reset mid-stream abandons the vector; no partial resume.
- FSM states:
  - IDLE: out_valid=0, in_ready=1. If in_valid: capture in_data into the buffer, idx<=0, go to SEND.
  - SEND: out_valid=1, out_data=buffer[idx], out_index=idx, out_last=(idx==2N-1).
    - On out_valid&&out_ready with idx<2N-1: idx<=idx+1.
    - On out_valid&&out_ready with idx==2N-1 (last beat accepted):
      - if in_valid: capture the new vector, idx<=0, stay in SEND (back-to-back, no bubble);
      - else go to IDLE.
- in_ready = (state==IDLE) | (state==SEND & out_last & out_ready). This combinational path out_ready->in_ready is intentional.
- Latency: vector captured at edge t, element 0 valid at t+1. A vector takes exactly 2N beats when out_ready is held high. Throughput is 1 element/cycle.
- out_ready low: out_data, out_index, out_valid and out_last hold stable. No element is ever dropped or duplicated.
- in_data is sampled only on capture. Later changes on in_data have no effect on the vector in flight.
- Elements are emitted in buffer order (ascending). The block does not reorder.
- idx never wraps past 2N-1. The counter resets to 0 only on capture.

Optional Feature:
- Macro: MERGE_SER_SORT_CHECK_EN.
- With the macro: on each capture, combinationally check in_data element k <= element k+1 for all k in 0..2N-2 (unsigned). Any violation sets sort_err=1 on the capture edge. The flag is sticky until rst. The vector is still streamed unchanged.
- Without the macro: no checker logic; sort_err tied to 0. The port list is identical in both builds.

Decomposition:
- Shared package merge_pkg holds:
  - the default WIDTH and N constants;
  - the ELEMS = 2*N and CNT_W derivation;
  - the FSM state typedef (IDLE, SEND), also reused by future merge wrappers.
- Natural sub-module: merge_order_checker (parameterised WIDTH, N). A purely combinational "vector is nondecreasing" function block. It is instantiated only under MERGE_SER_SORT_CHECK_EN and is reusable on the merge8to16 output in other benches.

Test Plan:
- Basic stream: rst pulse, then in_data = elements 0..15 = {0,0,1,1,2,2,3,3,4,4,5,5,6,6,7,7}, out_ready=1. Required: in_ready drops, 16 beats follow with out_data equal to that sequence and out_index 0..15, out_last only on beat 16, then IDLE with in_ready=1.
- Backpressure: same vector, out_ready toggled 1,0,0,1,... Required: out_data/out_index stay stable while out_ready=0, all 16 values arrive exactly once in order, and in_data changes during SEND are ignored.
- Back-to-back: vector A (all 2s) followed by vector B (all 5s) with in_valid held high and out_ready=1. Required: B is captured on A's last beat, beat 17 is out_data=5 with out_index=0, and there is no idle cycle.
- Async reset mid-stream: assert rst at out_index=7 between clock edges. Required: out_valid=0, out_index=0 and in_ready=1 immediately, with no clock needed, and a new vector afterwards streams from index 0.
- Order check (with MERGE_SER_SORT_CHECK_EN): capture a vector with element 3=6 and element 4=2. Required: sort_err=1 from the capture edge and held through later valid vectors until rst, with data streamed unchanged. Without the macro, sort_err stays 0.
- Boundary values: vector of all 7s (max for WIDTH=3), then all 0s. Required: correct values, out_last asserted exactly once per vector, and idx never exceeds 15.
